// File: rtl/if_fetch_queue.sv
// Small FIFO used for the fetch address and instruction queues. Storage is zeroed on reset so heads read 0.
// Latency: a push is visible at the head on the next cycle. Push and pop may happen in the same cycle.
// Backpressure: none inside the FIFO. The caller never pushes when full or pops when empty. clr drops every entry.
module fetch_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   push,
  input  logic [W-1:0]           push_dat,
  input  logic                   pop,
  output logic [W-1:0]           head_dat,
  output logic [$clog2(DEPTH):0] cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      cnt <= cnt + CW'(1);
      else if (pop && !push) cnt <= cnt - CW'(1);
    end
  end

  assign head_dat = mem[rd_ptr];
endmodule

// Instruction fetch: owns the PC, issues in-order imem requests and queues {pc, instr} for decode.
// Latency: a response in cycle N is visible to decode in cycle N+1. Throughput is 1/cycle when memory latency <= DEPTH-1.
// Backpressure: instr_ready low holds the head stable. New requests stop once DEPTH fetches are outstanding or buffered.
module if_fetch_queue #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = {WIDTH{1'b0}},
  parameter int               DEPTH    = 2
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-1:0] imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [WIDTH-1:0] imem_rsp_data,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [WIDTH-1:0] instr_out,
  output logic [WIDTH-1:0] pc_out
);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] pc, pc_nxt;
  logic [CW-1:0]    drop_cnt, drop_cnt_nxt;
  logic [CW-1:0]    addr_cnt, data_cnt, outstanding, stale_base, stale;
  logic             redir, req_fire, instr_fire, rsp_push;

  assign redir       = redirect_valid && (state != IDLE);
  assign outstanding = addr_cnt - data_cnt;

  assign instr_valid = (data_cnt != '0) && !redirect_valid;
  assign instr_fire  = instr_valid && instr_ready;

  // A pop in the same cycle frees an address slot, which keeps full throughput at DEPTH=2.
  assign imem_req_valid = (state == RUN) && !redirect_valid &&
                          ((addr_cnt != CW'(DEPTH)) || instr_fire);
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses still owed by memory when a redirect lands. The one arriving this cycle is already accounted for.
  assign stale_base = (state == FLUSH) ? drop_cnt : outstanding;
  assign stale      = (imem_rsp_valid && (stale_base != '0)) ? stale_base - CW'(1) : stale_base;

  assign rsp_push = imem_rsp_valid && !redir && (drop_cnt == '0) && (outstanding != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      drop_cnt <= '0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      drop_cnt <= drop_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    drop_cnt_nxt = drop_cnt;
    if (state == IDLE) begin
      state_nxt = RUN;
    end else if (redir) begin
      pc_nxt       = redirect_pc & ~WIDTH'(3);
      drop_cnt_nxt = stale;
      state_nxt    = (stale != '0) ? FLUSH : RUN;
    end else begin
      if (req_fire) pc_nxt = pc + WIDTH'(4);
      if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt_nxt = drop_cnt - CW'(1);
      if ((state == FLUSH) && (drop_cnt_nxt == '0)) state_nxt = RUN;
    end
  end

  fetch_fifo #(.W(WIDTH), .DEPTH(DEPTH)) addr_q (
    .clk      (clk),
    .rst      (rst),
    .clr      (redir),
    .push     (req_fire),
    .push_dat (pc),
    .pop      (instr_fire),
    .head_dat (pc_out),
    .cnt      (addr_cnt)
  );

  fetch_fifo #(.W(WIDTH), .DEPTH(DEPTH)) data_q (
    .clk      (clk),
    .rst      (rst),
    .clr      (redir),
    .push     (rsp_push),
    .push_dat (imem_rsp_data),
    .pop      (instr_fire),
    .head_dat (instr_out),
    .cnt      (data_cnt)
  );

  // A response with nothing outstanding and nothing to drop is a memory protocol error.
  assert property (@(posedge clk) disable iff (rst)
    !(imem_rsp_valid && (outstanding == '0) && (drop_cnt == '0)));
endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: a fixed-latency memory model, a scoreboard of expected PCs and a decoupled monitor.
module tb_if_fetch_queue;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_out;
  logic [31:0] pc_out;

  if_fetch_queue #(.WIDTH(32), .RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_out      (instr_out),
    .pc_out         (pc_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } pend_t;

  pend_t       pend[$];
  logic [31:0] exp_q[$];
  logic [31:0] req_log[$];
  logic [31:0] mon_want;
  int          cyc = 0;
  int          lat = 1;
  int          n_cmp = 0;
  int          n_err = 0;
  logic        nxt_rst = 1'b1, nxt_ready = 1'b0, nxt_redir = 1'b0;
  logic [31:0] nxt_redir_pc = '0;
  logic        s_req_valid, s_instr_valid, s_instr_fire;
  logic [31:0] s_req_addr, s_instr_out, s_pc_out;

  // Memory contents are a fixed scramble of the address, so a stale word shows up against its PC.
  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  task automatic chk_log(input string name, input int idx, input logic [31:0] want);
    if (idx < req_log.size()) chk(name, req_log[idx], want);
    else begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: request %0d never issued, expected addr %h", name, idx, want);
    end
  endtask

  // One cycle: drive inputs after negedge, present due responses, sample, and log the request handshake.
  task automatic step();
    @(negedge clk);
    cyc++;
    rst            = nxt_rst;
    instr_ready    = nxt_ready;
    redirect_valid = nxt_redir;
    redirect_pc    = nxt_redir_pc;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (nxt_rst) pend.delete();
    else if (pend.size() > 0 && pend[0].due == cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word(pend[0].addr);
      pend.delete(0);
    end
    #1;
    s_req_valid   = imem_req_valid;
    s_req_addr    = imem_req_addr;
    s_instr_valid = instr_valid;
    s_instr_fire  = instr_valid && instr_ready;
    s_instr_out   = instr_out;
    s_pc_out      = pc_out;
    if (!rst && imem_req_valid && imem_req_ready) begin
      pend.push_back('{due: cyc + lat, addr: imem_req_addr});
      req_log.push_back(imem_req_addr);
    end
    #2;
  endtask

  task automatic do_reset();
    nxt_rst   = 1'b1;
    nxt_redir = 1'b0;
    nxt_ready = 1'b0;
    step();
    nxt_rst = 1'b0;
    req_log.delete();
  endtask

  task automatic drain(input string name, input int max);
    nxt_ready = 1'b1;
    for (int i = 0; i < max && exp_q.size() > 0; i++) step();
    nxt_ready = 1'b0;
    chk(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic redirect_to(input logic [31:0] target, input logic ready);
    nxt_redir    = 1'b1;
    nxt_redir_pc = target;
    nxt_ready    = ready;
    step();
    nxt_redir = 1'b0;
    nxt_ready = 1'b0;
    req_log.delete();
  endtask

  // Scoreboard monitor: every decode handshake consumes one expected PC.
  always @(negedge clk) begin
    #2;
    if (!rst && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_instr: pc_out=%h instr_out=%h, none expected", pc_out, instr_out);
      end else begin
        mon_want = exp_q.pop_front();
        chk("pc_out", pc_out, mon_want);
        chk("instr_out", instr_out, word(mon_want));
      end
    end
  end

  initial begin
    int r1, first_v, last_f;

    // 1: reset values, first-valid latency, back-to-back stream with 1-cycle memory
    do_reset();
    lat = 1;
    nxt_ready = 1'b1;
    for (int a = 0; a < 32; a += 4) exp_q.push_back(32'(a));
    step();
    r1 = cyc;
    chk("rst_req_valid", {31'd0, s_req_valid}, 32'd0);
    chk("rst_instr_valid", {31'd0, s_instr_valid}, 32'd0);
    chk("rst_instr_out", s_instr_out, 32'd0);
    chk("rst_pc_out", s_pc_out, 32'd0);
    chk("rst_req_addr", s_req_addr, 32'd0);
    first_v = -1;
    last_f  = -1;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
      step();
      if (s_instr_valid && first_v < 0) first_v = cyc;
      if (s_instr_fire) last_f = cyc;
    end
    nxt_ready = 1'b0;
    chk("t1_first_valid_latency", 32'(first_v - r1), 32'd3);
    chk("t1_burst_span", 32'(last_f - first_v), 32'd7);
    chk("t1_leftover", 32'(exp_q.size()), 32'd0);
    chk_log("t1_req0", 0, 32'h0);
    chk_log("t1_req1", 1, 32'h4);
    chk_log("t1_req2", 2, 32'h8);
    chk_log("t1_req3", 3, 32'hC);
    exp_q.delete();

    // 2: decode stalled for 6 cycles: exactly DEPTH requests, stable head, lossless drain
    do_reset();
    lat = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i >= 3) begin
        chk("t2_head_valid", {31'd0, s_instr_valid}, 32'd1);
        chk("t2_head_pc", s_pc_out, 32'h0);
        chk("t2_head_instr", s_instr_out, word(32'h0));
      end
    end
    chk("t2_req_count", 32'(req_log.size()), 32'd2);
    chk("t2_req_valid_low", {31'd0, s_req_valid}, 32'd0);
    for (int a = 0; a < 16; a += 4) exp_q.push_back(32'(a));
    drain("t2_leftover", 20);

    // 3: redirect with two responses in flight (3-cycle memory), both must be dropped
    do_reset();
    lat = 3;
    repeat (3) step();
    chk("t3_inflight", 32'(req_log.size()), 32'd2);
    redirect_to(32'h100, 1'b0);
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    exp_q.push_back(32'h108);
    drain("t3_leftover", 30);
    chk_log("t3_first_req", 0, 32'h100);
    chk_log("t3_second_req", 1, 32'h104);

    // 4a: redirect coincides with a response and a ready head: no handshake, response discarded
    do_reset();
    lat = 2;
    repeat (4) step();
    redirect_to(32'h40, 1'b1);
    chk("t4a_instr_valid", {31'd0, s_instr_valid}, 32'd0);
    chk("t4a_no_handshake", {31'd0, s_instr_fire}, 32'd0);
    chk("t4a_req_valid", {31'd0, s_req_valid}, 32'd0);
    exp_q.push_back(32'h40);
    exp_q.push_back(32'h44);
    drain("t4a_leftover", 20);
    chk_log("t4a_first_req", 0, 32'h40);

    // 4b: same, but one more response is still in flight and must be dropped
    do_reset();
    lat = 3;
    repeat (4) step();
    redirect_to(32'h80, 1'b1);
    chk("t4b_no_handshake", {31'd0, s_instr_fire}, 32'd0);
    exp_q.push_back(32'h80);
    exp_q.push_back(32'h84);
    drain("t4b_leftover", 30);
    chk_log("t4b_first_req", 0, 32'h80);

    // 5: misaligned target is word-aligned; fetch wraps from the top of the address space
    do_reset();
    lat = 1;
    repeat (3) step();
    redirect_to(32'h203, 1'b0);
    exp_q.push_back(32'h200);
    exp_q.push_back(32'h204);
    drain("t5a_leftover", 20);
    chk_log("t5a_first_req", 0, 32'h200);
    redirect_to(32'hFFFF_FFFC, 1'b0);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    drain("t5b_leftover", 20);
    chk_log("t5b_first_req", 0, 32'hFFFF_FFFC);
    chk_log("t5b_wrap_req", 1, 32'h0);

    // 6: reset while flushing returns every output to reset values
    do_reset();
    lat = 1;
    exp_q.push_back(32'h0);
    repeat (4) step();
    lat = 3;
    nxt_ready = 1'b1;
    step();
    chk("t6_pre_pop", 32'(exp_q.size()), 32'd0);
    redirect_to(32'h300, 1'b0);
    nxt_rst = 1'b1;
    step();
    chk("t6_flush_no_req", {31'd0, s_req_valid}, 32'd0);
    nxt_rst = 1'b0;
    req_log.delete();
    step();
    chk("t6_req_valid", {31'd0, s_req_valid}, 32'd0);
    chk("t6_instr_valid", {31'd0, s_instr_valid}, 32'd0);
    chk("t6_instr_out", s_instr_out, 32'd0);
    chk("t6_pc_out", s_pc_out, 32'd0);
    chk("t6_req_addr", s_req_addr, 32'd0);
    for (int i = 0; i < 5 && req_log.size() == 0; i++) step();
    chk_log("t6_first_req", 0, 32'h0);
    exp_q.push_back(32'h0);
    drain("t6_leftover", 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
